// File: rtl/in_port_pkg.sv
// Shared PHV geometry for the ingress deserializer and the egress serializer.
package in_port_pkg;

  localparam int unsigned PHV_BYTES  = 128;
  localparam int unsigned BEAT_BYTES = 32;
  localparam int unsigned BEATS      = PHV_BYTES / BEAT_BYTES;
  localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W      = 32;

  // Byte i of a PHV is element [i].
  typedef logic [PHV_BYTES-1:0][7:0]  phv_bytes_t;
  typedef logic [BEAT_BYTES-1:0][7:0] beat_bytes_t;
  typedef logic [BEAT_IDX_W-1:0]      beat_idx_t;
  typedef logic [BEATS-1:0]           lane_en_t;

endpackage

// File: rtl/in_port_if.sv
// Beat stream in, PHV out. The slave modport is the deserializer side.
interface in_port_if;
  import in_port_pkg::*;

  beat_bytes_t       io_data;
  logic              io_last;
  logic              io_en;

  phv_bytes_t        io_phv_out_data;
  logic              io_phv_out_valid;
  logic              io_phv_out_last;
  logic [CNT_W-1:0]  io_pkt_cnt;

  modport slave (
    input  io_data, io_last, io_en,
    output io_phv_out_data, io_phv_out_valid, io_phv_out_last, io_pkt_cnt
  );

  modport master (
    output io_data, io_last, io_en,
    input  io_phv_out_data, io_phv_out_valid, io_phv_out_last, io_pkt_cnt
  );

endinterface

// File: rtl/in_port.sv
// Ingress PHV deserializer: packs BEAT_BYTES-wide beats into PHV_BYTES-wide PHVs.
// A PHV is emitted one cycle after the beat that fills it or that carries io_last.
module in_port
  import in_port_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  in_port_if.slave    bus
);

  beat_idx_t         beat_idx_q, beat_idx_d;
  phv_bytes_t        acc_q, acc_d;
  phv_bytes_t        phv_q, phv_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  lane_en_t          lane_sel;
  phv_bytes_t        merged;
  logic              complete;

  // One-hot beat lane select decoded from the current fill index.
  always_comb begin
    lane_sel = '0;
    lane_sel[beat_idx_q] = 1'b1;
  end

  // Accumulator with the current beat written into its lane.
  always_comb begin
    merged = acc_q;
    for (int b = 0; b < BEATS; b++) begin
      if (bus.io_en && lane_sel[b]) begin
        merged[b*BEAT_BYTES +: BEAT_BYTES] = bus.io_data;
      end
    end
  end

  assign complete = bus.io_en && ((beat_idx_q == beat_idx_t'(BEATS - 1)) || bus.io_last);

  // Next-state: fill index, accumulator, registered PHV and packet counter.
  always_comb begin
    beat_idx_d = beat_idx_q;
    acc_d      = acc_q;
    phv_d      = phv_q;
    valid_d    = 1'b0;
    last_d     = last_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (complete) begin
      // The merged word goes out and the accumulator restarts empty, so a beat
      // arriving next cycle lands in a clean word.
      beat_idx_d = '0;
      acc_d      = '0;
      phv_d      = merged;
      valid_d    = 1'b1;
      last_d     = bus.io_last;
      if (bus.io_last) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end else if (bus.io_en) begin
      beat_idx_d = beat_idx_q + beat_idx_t'(1);
      acc_d      = merged;
    end
  end

  // State registers; reset discards any partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat_idx_q <= '0;
      acc_q      <= '0;
      phv_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      beat_idx_q <= beat_idx_d;
      acc_q      <= acc_d;
      phv_q      <= phv_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.io_phv_out_data  = phv_q;
  assign bus.io_phv_out_valid = valid_q;
  assign bus.io_phv_out_last  = last_q;
  assign bus.io_pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_in_port.sv
// Directed bench for in_port with a scoreboard of expected PHVs keyed by due cycle.
module tb_in_port;
  import in_port_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  in_port_if bus ();

  in_port dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    phv_bytes_t  data;
    logic        last;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  // Reference model state.
  phv_bytes_t  m_acc;
  int          m_idx;
  logic [31:0] m_cnt;
  phv_bytes_t  m_last_phv;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_phv(input string tag, input phv_bytes_t obs, input phv_bytes_t exp);
    int bad;
    bad = -1;
    for (int i = PHV_BYTES - 1; i >= 0; i--) begin
      if (obs[i] !== exp[i]) bad = i;
    end
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: first bad byte %0d observed=%0h expected=%0h", tag, bad, obs[bad],
             exp[bad]);
    end
  endtask

  // Advance one clock and compare against the scoreboard away from the edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check_val("valid", 32'(bus.io_phv_out_valid), 32'd1);
      check_phv("phv_data", bus.io_phv_out_data, e.data);
      check_val("phv_last", 32'(bus.io_phv_out_last), 32'(e.last));
      check_val("pkt_cnt", bus.io_pkt_cnt, m_cnt);
    end else begin
      check_val("valid_idle", 32'(bus.io_phv_out_valid), 32'd0);
    end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_idx = 0;
  endtask

  task automatic beat(input beat_bytes_t d, input logic l);
    exp_t e;
    bus.io_data = d;
    bus.io_last = l;
    bus.io_en   = 1'b1;
    for (int b = 0; b < BEAT_BYTES; b++) m_acc[m_idx*BEAT_BYTES + b] = d[b];
    if (m_idx == BEATS - 1 || l) begin
      if (l) m_cnt++;
      e.data = m_acc;
      e.last = l;
      e.due  = cyc + 1;
      sb.push_back(e);
      m_last_phv = m_acc;
      model_clear();
    end else begin
      m_idx++;
    end
    tick();
    bus.io_en   = 1'b0;
    bus.io_last = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.io_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic beat_bytes_t ramp(input int base);
    beat_bytes_t d;
    for (int b = 0; b < BEAT_BYTES; b++) d[b] = 8'(base + b);
    return d;
  endfunction

  function automatic beat_bytes_t fill(input logic [7:0] v);
    beat_bytes_t d;
    for (int b = 0; b < BEAT_BYTES; b++) d[b] = v;
    return d;
  endfunction

  initial begin
    phv_bytes_t exp_phv;

    model_clear();
    m_cnt      = '0;
    m_last_phv = '0;

    // Reset held while beats are being offered.
    bus.io_data = fill(8'hFF);
    bus.io_last = 1'b1;
    bus.io_en   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_phv("rst_data", bus.io_phv_out_data, '0);
    check_val("rst_last", 32'(bus.io_phv_out_last), 32'd0);
    check_val("rst_cnt", bus.io_pkt_cnt, 32'd0);
    bus.io_en   = 1'b0;
    bus.io_last = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // Full packet of four beats, byte i == i.
    for (int k = 0; k < BEATS; k++) beat(ramp(k * BEAT_BYTES), k == BEATS - 1);
    for (int i = 0; i < PHV_BYTES; i++) exp_phv[i] = 8'(i);
    check_phv("ramp_data", bus.io_phv_out_data, exp_phv);
    check_val("ramp_last", 32'(bus.io_phv_out_last), 32'd1);
    check_val("ramp_cnt", bus.io_pkt_cnt, 32'd1);
    idle(2);

    // Short packet: one beat, zero padded above.
    beat(fill(8'hAA), 1'b1);
    for (int i = 0; i < PHV_BYTES; i++) exp_phv[i] = (i < BEAT_BYTES) ? 8'hAA : 8'h00;
    check_phv("short_data", bus.io_phv_out_data, exp_phv);
    check_val("short_last", 32'(bus.io_phv_out_last), 32'd1);
    check_val("short_cnt", bus.io_pkt_cnt, 32'd2);
    idle(1);

    // Long packet: eight back-to-back beats, two PHVs.
    for (int k = 0; k < 2 * BEATS; k++) beat(ramp(8'h80 + k * 7), k == 2 * BEATS - 1);
    check_val("long_last", 32'(bus.io_phv_out_last), 32'd1);
    check_val("long_cnt", bus.io_pkt_cnt, 32'd3);

    // Idle gap inside a word; output must hold the previous PHV.
    beat(fill(8'h11), 1'b0);
    beat(fill(8'h22), 1'b0);
    idle(3);
    check_phv("gap_hold", bus.io_phv_out_data, m_last_phv);
    check_val("gap_hold_last", 32'(bus.io_phv_out_last), 32'd1);
    beat(fill(8'h33), 1'b0);
    beat(fill(8'h44), 1'b1);
    for (int i = 0; i < PHV_BYTES; i++) exp_phv[i] = 8'h11 * 8'(i / BEAT_BYTES + 1);
    check_phv("gap_data", bus.io_phv_out_data, exp_phv);
    check_val("gap_cnt", bus.io_pkt_cnt, 32'd4);

    // Last with en low must be ignored.
    bus.io_last = 1'b1;
    idle(2);
    bus.io_last = 1'b0;
    check_val("last_no_en_cnt", bus.io_pkt_cnt, 32'd4);

    // Async reset mid-word discards the partial word.
    beat(fill(8'h55), 1'b0);
    beat(fill(8'h66), 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_phv("mid_rst_data", bus.io_phv_out_data, '0);
    check_val("mid_rst_cnt", bus.io_pkt_cnt, 32'd0);
    check_val("mid_rst_valid", 32'(bus.io_phv_out_valid), 32'd0);
    model_clear();
    m_cnt = '0;
    idle(1);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < BEATS; k++) beat(fill(8'(8'hC0 + k)), k == BEATS - 1);
    for (int i = 0; i < PHV_BYTES; i++) exp_phv[i] = 8'(8'hC0 + i / BEAT_BYTES);
    check_phv("post_rst_data", bus.io_phv_out_data, exp_phv);
    check_val("post_rst_cnt", bus.io_pkt_cnt, 32'd1);
    idle(3);

    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
